// File: rtl/rot_pkg.sv
// rot_pkg: shared constants and types for the rotary quadrature decoder.
//   DIR_LEFT / DIR_RIGHT   : encoding of rot_dir (1 = CCW, 0 = CW)
//   DEBOUNCE_CYCLES_DEF    : default debounce length in clk edges
//   DEB_RST / Q1_RST / Q2_RST : reset values that make an idle (11) shaft
//                            come out of reset without a spurious step
//   quad_state_e           : debounced contact pair, packed as {deb_b, deb_a}
package rot_pkg;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  localparam logic DEB_RST = 1'b1;
  localparam logic Q1_RST  = 1'b1;
  localparam logic Q2_RST  = 1'b0;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_10 = 2'b10,
    QS_11 = 2'b11
  } quad_state_e;

endpackage

// File: rtl/rot_debounce.sv
// rot_debounce: two-flop synchroniser followed by a restartable debounce
// counter for one raw encoder contact.
//   clk      in  system clock
//   rst_n    in  async active-low reset (all flops return to idle-high)
//   raw_in   in  raw contact, asynchronous and bouncy
//   deb_out  out debounced level; follows sync2 only after it has differed
//                for DEBOUNCE_CYCLES consecutive edges
module rot_debounce
  import rot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic deb_out
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // Any sample that agrees with deb leaves cnt_d at zero, so a bounce
    // back restarts the count.
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_TC) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= DEB_RST;
      sync2_q <= DEB_RST;
      deb_q   <= DEB_RST;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_out = deb_q;

endmodule

// File: rtl/rot_quad_decoder.sv
// rot_quad_decoder: debounces ROT_A/ROT_B and turns each detent into a
// one-cycle step pulse with direction; flags double-contact jumps.
//   clk        in  system clock
//   rst_n      in  async active-low reset
//   ROT_A      in  raw contact A (async, bouncy)
//   ROT_B      in  raw contact B (async, bouncy)
//   rot_event  out one-cycle pulse per detent step (rising edge of q1)
//   rot_dir    out direction of the latest step, 1 = CCW, held between steps
//   rot_err    out one-cycle pulse when both debounced contacts change together
//
// q1 tracks the last diagonal state seen (00 -> 0, 11 -> 1) and q2 the last
// off-diagonal one ({B,A} 01 -> 0, 10 -> 1). A detent completes when q1
// rises; q2 at that moment tells which side the shaft approached 11 from.
module rot_quad_decoder
  import rot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ROT_A,
  input  logic ROT_B,
  output logic rot_event,
  output logic rot_dir,
  output logic rot_err
);

  logic deb_a, deb_b;

  rot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (ROT_A),
    .deb_out(deb_a)
  );

  rot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (ROT_B),
    .deb_out(deb_b)
  );

  logic deb_a_prev_q, deb_a_prev_d;
  logic deb_b_prev_q, deb_b_prev_d;
  logic q1_q, q1_d;
  logic q2_q, q2_d;
  logic q1_dly_q, q1_dly_d;
  logic q2_dly_q, q2_dly_d;
  logic rot_event_q, rot_event_d;
  logic rot_dir_q, rot_dir_d;
  logic rot_err_q, rot_err_d;
  logic jump;
  logic step;

  always_comb begin
    deb_a_prev_d = deb_a;
    deb_b_prev_d = deb_b;
    q1_d         = q1_q;
    q2_d         = q2_q;
    q1_dly_d     = q1_q;
    q2_dly_d     = q2_q;

    unique case (quad_state_e'({deb_b, deb_a}))
      QS_00:   q1_d = 1'b0;
      QS_11:   q1_d = 1'b1;
      QS_01:   q2_d = 1'b0;
      QS_10:   q2_d = 1'b1;
      default: q1_d = q1_q;
    endcase

    jump      = (deb_a != deb_a_prev_q) && (deb_b != deb_b_prev_q);
    rot_err_d = jump;

    // rot_err_q is high exactly in the cycle where a jump-induced q1 rise
    // would be turned into an event, so it doubles as the suppress flag.
    step        = q1_q && !q1_dly_q && !rot_err_q;
    rot_event_d = step;
    rot_dir_d   = rot_dir_q;
    if (step) begin
      rot_dir_d = q2_dly_q ? DIR_LEFT : DIR_RIGHT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_a_prev_q <= DEB_RST;
      deb_b_prev_q <= DEB_RST;
      q1_q         <= Q1_RST;
      q2_q         <= Q2_RST;
      q1_dly_q     <= Q1_RST;
      q2_dly_q     <= Q2_RST;
      rot_event_q  <= 1'b0;
      rot_dir_q    <= DIR_RIGHT;
      rot_err_q    <= 1'b0;
    end else begin
      deb_a_prev_q <= deb_a_prev_d;
      deb_b_prev_q <= deb_b_prev_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      q1_dly_q     <= q1_dly_d;
      q2_dly_q     <= q2_dly_d;
      rot_event_q  <= rot_event_d;
      rot_dir_q    <= rot_dir_d;
      rot_err_q    <= rot_err_d;
    end
  end

  assign rot_event = rot_event_q;
  assign rot_dir   = rot_dir_q;
  assign rot_err   = rot_err_q;

endmodule

// File: tb/tb_rot_quad_decoder.sv
// Testbench for rot_quad_decoder with DEBOUNCE_CYCLES = 4.
// A reference model at contact-state level predicts debounced transitions
// from the raw sample history and pushes expected events/errors into queues;
// a monitor pops and compares whenever the DUT pulses an output.
module tb_rot_quad_decoder;
  import rot_pkg::*;

  localparam int D    = 4;
  localparam int MAXE = 30000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rot_a = 1'b1;
  logic rot_b = 1'b1;
  logic rot_event, rot_dir, rot_err;

  always #5 clk = ~clk;

  rot_quad_decoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ROT_A    (rot_a),
    .ROT_B    (rot_b),
    .rot_event(rot_event),
    .rot_dir  (rot_dir),
    .rot_err  (rot_err)
  );

  typedef struct {
    int   edge_no;
    logic dir;
  } ev_t;

  int  errors = 0;
  int  checks = 0;
  int  edge_n = 0;
  int  events_seen = 0;
  int  errs_seen = 0;
  int  last_event_edge = 0;
  bit  samp_a [MAXE];
  bit  samp_b [MAXE];
  ev_t ev_q[$];
  int  err_q[$];

  bit m_deb_a = 1'b1, m_deb_b = 1'b1, m_diag = 1'b1, m_off = 1'b0;

  // A contact level becomes the debounced value once the last D samples
  // that have made it through the synchroniser all disagree with it.
  function automatic bit flips(input int t, input bit use_b, input bit cur);
    bit s;
    for (int k = t - D - 1; k <= t - 2; k++) begin
      if (k < 1) s = 1'b1;
      else       s = use_b ? samp_b[k] : samp_a[k];
      if (s == cur) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit na, nb, ch_a, ch_b;
    edge_n = edge_n + 1;
    if (edge_n < MAXE) begin
      if (!rst_n) begin
        samp_a[edge_n] = 1'b1;
        samp_b[edge_n] = 1'b1;
        m_deb_a = 1'b1; m_deb_b = 1'b1; m_diag = 1'b1; m_off = 1'b0;
        ev_q.delete();
        err_q.delete();
      end else begin
        samp_a[edge_n] = rot_a;
        samp_b[edge_n] = rot_b;
        na   = flips(edge_n, 1'b0, m_deb_a) ? ~m_deb_a : m_deb_a;
        nb   = flips(edge_n, 1'b1, m_deb_b) ? ~m_deb_b : m_deb_b;
        ch_a = (na != m_deb_a);
        ch_b = (nb != m_deb_b);
        if (ch_a && ch_b) err_q.push_back(edge_n + 1);
        if (ch_a || ch_b) begin
          if (na && nb) begin
            if (!m_diag && !(ch_a && ch_b)) ev_q.push_back('{edge_n + 2, m_off});
            m_diag = 1'b1;
          end else if (!na && !nb) begin
            m_diag = 1'b0;
          end else if (na && !nb) begin
            m_off = 1'b0;
          end else begin
            m_off = 1'b1;
          end
        end
        m_deb_a = na;
        m_deb_b = nb;
      end
    end
  end

  logic prev_event = 1'b0;
  logic prev_dir   = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    int  ee;
    if (rst_n) begin
      while (ev_q.size() > 0 && ev_q[0].edge_no < edge_n) begin
        e = ev_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event: no pulse, expected at edge %0d", e.edge_no);
      end
      while (err_q.size() > 0 && err_q[0] < edge_n) begin
        ee = err_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_err: no pulse, expected at edge %0d", ee);
      end
      if (rot_event) begin
        events_seen++;
        last_event_edge = edge_n;
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: event at edge %0d, expected none", edge_n);
        end else begin
          e = ev_q.pop_front();
          if (e.edge_no != edge_n || e.dir !== rot_dir) begin
            errors++;
            $display("FAIL event: edge %0d dir %0b, expected edge %0d dir %0b",
                     edge_n, rot_dir, e.edge_no, e.dir);
          end
        end
      end
      if (rot_err) begin
        errs_seen++;
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err: err at edge %0d, expected none", edge_n);
        end else begin
          ee = err_q.pop_front();
          if (ee != edge_n) begin
            errors++;
            $display("FAIL err_time: err at edge %0d, expected edge %0d", edge_n, ee);
          end
        end
      end
      checks++;
      if (rot_event && prev_event) begin
        errors++;
        $display("FAIL event_width: high 2 cycles at edge %0d, expected 1", edge_n);
      end
      checks++;
      if (!rot_event && rot_dir !== prev_dir) begin
        errors++;
        $display("FAIL dir_hold: dir %0b without event, expected %0b", rot_dir, prev_dir);
      end
    end
    prev_event = rot_event;
    prev_dir   = rot_dir;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ab(input bit a, input bit b, input int hold);
    @(negedge clk);
    rot_a = a;
    rot_b = b;
    repeat (hold) @(negedge clk);
  endtask

  // Drives A last; returns the edge at which sync1 first samples that change.
  task automatic seq_left(output int s);
    set_ab(1, 0, 10);
    set_ab(0, 0, 10);
    set_ab(0, 1, 10);
    @(negedge clk);
    rot_a = 1'b1;
    s = edge_n + 1;
    repeat (12) @(negedge clk);
  endtask

  task automatic seq_right(output int s);
    set_ab(0, 1, 10);
    set_ab(0, 0, 10);
    set_ab(1, 0, 10);
    @(negedge clk);
    rot_a = 1'b1;
    rot_b = 1'b1;
    s = edge_n + 1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, ev0, er0, bits;
    repeat (3) @(negedge clk);
    chk("reset_event", rot_event, 0);
    chk("reset_dir", rot_dir, 0);
    chk("reset_err", rot_err, 0);
    #2 rst_n = 1'b1;

    repeat (50) @(negedge clk);
    chk("idle_events", events_seen, 0);
    chk("idle_errs", errs_seen, 0);
    chk("idle_dir", rot_dir, 0);

    ev0 = events_seen;
    seq_left(s);
    chk("left_count", events_seen - ev0, 1);
    chk("left_latency", last_event_edge - s, 7);
    chk("left_dir", rot_dir, int'(DIR_LEFT));

    ev0 = events_seen;
    seq_right(s);
    chk("right_count", events_seen - ev0, 1);
    chk("right_latency", last_event_edge - s, 7);
    chk("right_dir", rot_dir, int'(DIR_RIGHT));

    // Bounce A while at AB=01, settle high to complete a left step.
    set_ab(1, 0, 10);
    set_ab(0, 0, 10);
    set_ab(0, 1, 10);
    ev0 = events_seen;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rot_a = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    rot_a = 1'b1;
    s = edge_n + 1;
    repeat (12) @(negedge clk);
    chk("bounce_count", events_seen - ev0, 1);
    chk("bounce_latency", last_event_edge - s, 7);

    // Double-contact jumps in both directions.
    ev0 = events_seen;
    er0 = errs_seen;
    set_ab(0, 0, 10);
    set_ab(1, 1, 12);
    chk("jump_errs", errs_seen - er0, 2);
    chk("jump_events", events_seen - ev0, 0);

    // Reset two cycles into a 01->11 debounce.
    set_ab(0, 1, 10);
    ev0 = events_seen;
    @(negedge clk);
    rot_a = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_event", rot_event, 0);
    chk("midrst_dir", rot_dir, 0);
    chk("midrst_err", rot_err, 0);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_event", events_seen - ev0, 0);
    ev0 = events_seen;
    seq_left(s);
    chk("post_rst_count", events_seen - ev0, 1);
    chk("post_rst_latency", last_event_edge - s, 7);
    chk("post_rst_dir", rot_dir, int'(DIR_LEFT));

    // Random walk: gray steps, jumps and glitches.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      @(negedge clk);
      if (kind < 7) begin
        if ($urandom_range(0, 1) == 0) rot_a = ~rot_a;
        else                           rot_b = ~rot_b;
      end else if (kind == 7) begin
        rot_a = ~rot_a;
        rot_b = ~rot_b;
      end else begin
        bits = $urandom_range(1, 6);
        if (kind == 8) rot_a = ~rot_a; else rot_b = ~rot_b;
        repeat (bits) @(negedge clk);
        if (kind == 8) rot_a = ~rot_a; else rot_b = ~rot_b;
      end
      repeat ($urandom_range(6, 14)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("ev_queue_empty", ev_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
